// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT magnitude streamer and its helpers.
//   bin_t   : one FFT bin, {re[15:8], im[7:0]}, both two's complement
//   N_BINS  : bins per frame
//   MAG_W   : magnitude byte width
//   state_t : streamer control states
//   abs8    : 8-bit two's-complement magnitude (|-128| = 128 as unsigned)
package fft_pkg;

  localparam int N_BINS = 4;
  localparam int MAG_W  = 8;
  localparam int IDX_W  = 2;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
  } bin_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    COMPUTE = 3'd2,
    READY   = 3'd3,
    DRIVE   = 3'd4
  } state_t;

  // Unsigned magnitude of a signed byte; -128 maps to 8'h80 without wrapping.
  function automatic logic [7:0] abs8(input logic [7:0] x);
    if (x[7]) begin
      abs8 = (~x) + 8'd1;
    end else begin
      abs8 = x;
    end
  endfunction

endpackage

// File: rtl/fft_cmag_approx.sv
// fft_cmag_approx: combinational alpha-max-plus-beta-min magnitude estimate.
//   bin : input bin_t, one complex sample
//   mag : output [7:0], max(|re|,|im|) + (min(|re|,|im|) >> 1)
// The result never exceeds 128 + 64 = 192, so 8 bits hold it without saturation.
module fft_cmag_approx
  import fft_pkg::*;
(
  input  bin_t             bin,
  output logic [MAG_W-1:0] mag
);

  logic [7:0] abs_re_s;
  logic [7:0] abs_im_s;
  logic [7:0] hi_s;
  logic [7:0] lo_s;

  // Order the two magnitudes and combine them.
  always_comb begin
    abs_re_s = abs8(bin.re);
    abs_im_s = abs8(bin.im);
    if (abs_re_s >= abs_im_s) begin
      hi_s = abs_re_s;
      lo_s = abs_im_s;
    end else begin
      hi_s = abs_im_s;
      lo_s = abs_re_s;
    end
    mag = hi_s + (lo_s >> 1);
  end

endmodule

// File: rtl/fft_mag_streamer.sv
// fft_mag_streamer: captures a 4-bin FFT result, computes one magnitude byte
// per bin (one bin per cycle), then streams the bytes out on request.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : one-cycle pulse, in_bins holds a frame
//   in_bins[0..3]   : bins {re, im}
//   out_req         : one-cycle pulse asking for the next byte
//   out_byte        : magnitude byte (0 when out_valid is low)
//   out_valid       : high for the cycle out_byte is presented
//   out_oe          : 8'hFF while out_valid, else 8'h00
//   busy, ready     : not IDLE / in READY
//   frame_done      : pulse with the last byte of a frame
//   peak_idx        : index of the largest magnitude (lowest index on ties)
//   overrun         : sticky, an in_valid was ignored; cleared on next accepted frame
// All outputs are registered and derived from the next-state values, so they
// line up with the state they describe.
module fft_mag_streamer
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  bin_t             in_bins [N_BINS],
  input  logic             out_req,
  output logic [MAG_W-1:0] out_byte,
  output logic             out_valid,
  output logic [7:0]       out_oe,
  output logic             busy,
  output logic             ready,
  output logic             frame_done,
  output logic [IDX_W-1:0] peak_idx,
  output logic             overrun
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] j_q, j_d;
  bin_t             bins_q [N_BINS];
  bin_t             bins_d [N_BINS];
  logic [MAG_W-1:0] mag_q  [N_BINS];
  logic [MAG_W-1:0] mag_d  [N_BINS];
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
  logic             overrun_q, overrun_d;
  logic [MAG_W-1:0] out_byte_q, out_byte_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_oe_q, out_oe_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             frame_done_q, frame_done_d;

  logic [MAG_W-1:0] cur_mag_s;
  logic [MAG_W-1:0] mag_upd_s [N_BINS];
  logic [MAG_W-1:0] best_s;
  logic [IDX_W-1:0] best_idx_s;

  fft_cmag_approx u_cmag (
    .bin (bins_q[k_q]),
    .mag (cur_mag_s)
  );

  // Magnitude table with the bin under computation replaced, and its peak.
  always_comb begin
    mag_upd_s      = mag_q;
    mag_upd_s[k_q] = cur_mag_s;
    best_s         = mag_upd_s[0];
    best_idx_s     = 2'd0;
    for (int i = 1; i < N_BINS; i++) begin
      // Strict compare keeps the lowest index on a tie.
      if (mag_upd_s[i] > best_s) begin
        best_s     = mag_upd_s[i];
        best_idx_s = i[IDX_W-1:0];
      end else begin
        best_s     = best_s;
        best_idx_s = best_idx_s;
      end
    end
  end

  // Next-state logic and registered-output values.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    bins_d     = bins_q;
    mag_d      = mag_q;
    peak_idx_d = peak_idx_q;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: begin
        // in_valid wins over a simultaneous out_req.
        if (in_valid) begin
          state_d   = CAPTURE;
          bins_d    = in_bins;
          overrun_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        state_d = COMPUTE;
        k_d     = 2'd0;
      end
      COMPUTE: begin
        mag_d = mag_upd_s;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d    = READY;
          peak_idx_d = best_idx_s;
        end else begin
          state_d = COMPUTE;
        end
      end
      READY: begin
        if (out_req) begin
          state_d = DRIVE;
        end else begin
          state_d = READY;
        end
      end
      DRIVE: begin
        j_d = j_q + 2'd1;
        if (j_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 2'd0;
        j_d     = 2'd0;
      end
    endcase

    // A frame in flight is never disturbed; the ignored pulse is only flagged.
    if (in_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end

    out_valid_d  = (state_d == DRIVE);
    out_oe_d     = out_valid_d ? 8'hFF : 8'h00;
    out_byte_d   = out_valid_d ? mag_d[j_d] : 8'h00;
    busy_d       = (state_d != IDLE);
    ready_d      = (state_d == READY);
    frame_done_d = out_valid_d && (j_d == 2'd3);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      j_q          <= 2'd0;
      bins_q       <= '{default: '0};
      mag_q        <= '{default: '0};
      peak_idx_q   <= 2'd0;
      overrun_q    <= 1'b0;
      out_byte_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      out_oe_q     <= 8'h00;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      j_q          <= j_d;
      bins_q       <= bins_d;
      mag_q        <= mag_d;
      peak_idx_q   <= peak_idx_d;
      overrun_q    <= overrun_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      out_oe_q     <= out_oe_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
  assign out_oe     = out_oe_q;
  assign busy       = busy_q;
  assign ready      = ready_q;
  assign frame_done = frame_done_q;
  assign peak_idx   = peak_idx_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fft_mag_streamer.sv
// tb_fft_mag_streamer: directed and randomized frames checked against a
// plain-arithmetic magnitude/peak model.
module tb_fft_mag_streamer;
  import fft_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  bin_t       in_bins [N_BINS];
  logic       out_req;
  logic [7:0] out_byte;
  logic       out_valid;
  logic [7:0] out_oe;
  logic       busy;
  logic       ready;
  logic       frame_done;
  logic [1:0] peak_idx;
  logic       overrun;

  int compared   = 0;
  int mismatched = 0;
  int acc_mag [4];
  int acc_peak;

  fft_mag_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bins    (in_bins),
    .out_req    (out_req),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_oe     (out_oe),
    .busy       (busy),
    .ready      (ready),
    .frame_done (frame_done),
    .peak_idx   (peak_idx),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_mag(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    return (a > b) ? (a + b / 2) : (b + a / 2);
  endfunction

  task automatic set_bin(input int idx, input int re, input int im);
    in_bins[idx].re = 8'(re);
    in_bins[idx].im = 8'(im);
  endtask

  task automatic set_random_bins();
    for (int i = 0; i < 4; i++) set_bin(i, $urandom_range(255) - 128, $urandom_range(255) - 128);
  endtask

  // Snapshot the expected frame from the bins currently on the port.
  task automatic model_frame();
    int best;
    best = -1;
    for (int i = 0; i < 4; i++) begin
      acc_mag[i] = ref_mag(int'($signed(in_bins[i].re)), int'($signed(in_bins[i].im)));
      if (acc_mag[i] > best) begin
        best     = acc_mag[i];
        acc_peak = i;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_oe"}, out_oe, 0);
    check({tag, "_byte"}, out_byte, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_fdone"}, frame_done, 0);
  endtask

  // Accept a frame and verify the E0..E5 latency and resulting peak.
  task automatic start_frame(input string tag, input logic with_req);
    model_frame();
    in_valid = 1'b1;
    out_req  = with_req;
    step();
    in_valid = 1'b0;
    out_req  = 1'b0;
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_ovr_clr"}, overrun, 0);
    check({tag, "_novalid_e0"}, out_valid, 0);
    for (int e = 1; e <= 4; e++) begin
      check({tag, "_notready"}, ready, 0);
      step();
    end
    check({tag, "_notready_e4"}, ready, 0);
    step();
    check({tag, "_ready_e5"}, ready, 1);
    check({tag, "_peak"}, peak_idx, acc_peak);
  endtask

  task automatic read_byte(input string tag, input int j);
    out_req = 1'b1;
    step();
    out_req = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_oe"}, out_oe, 8'hFF);
    check({tag, "_byte"}, out_byte, acc_mag[j]);
    check({tag, "_fdone"}, frame_done, (j == 3) ? 1 : 0);
    step();
    check({tag, "_valid_off"}, out_valid, 0);
    check({tag, "_byte_off"}, out_byte, 0);
    check({tag, "_ready_after"}, ready, (j == 3) ? 0 : 1);
    check({tag, "_busy_after"}, busy, (j == 3) ? 0 : 1);
  endtask

  task automatic read_frame(input string tag);
    for (int j = 0; j < 4; j++) read_byte(tag, j);
  endtask

  initial begin
    int n;
    int sav [4];
    rst      = 1'b1;
    in_valid = 1'b0;
    out_req  = 1'b0;
    for (int i = 0; i < 4; i++) set_bin(i, 0, 0);
    step();
    step();
    check_idle_outputs("rst");
    check("rst_peak", peak_idx, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    step();

    // Basic frame: bytes 5,0,14,1, peak 2.
    set_bin(0, 3, 4); set_bin(1, 0, 0); set_bin(2, -5, 12); set_bin(3, 1, -1);
    start_frame("f1", 1'b0);
    read_frame("f1");

    // Extremes: bytes 128,192,190,128, peak 1.
    set_bin(0, -128, 0); set_bin(1, -128, -128); set_bin(2, 127, 127); set_bin(3, 0, -128);
    start_frame("f2", 1'b0);
    read_frame("f2");

    // Ties resolve to the lowest index.
    set_bin(0, 0, 0); set_bin(1, 5, 0); set_bin(2, 0, -5); set_bin(3, -5, 0);
    start_frame("tie", 1'b0);
    read_frame("tie");

    // out_req outside READY is ignored.
    out_req = 1'b1;
    step();
    check("idle_req_valid", out_valid, 0);
    out_req = 1'b0;

    // Overrun during READY leaves the frame intact.
    set_random_bins();
    start_frame("ovr", 1'b0);
    sav = acc_mag;
    set_random_bins();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_ready", ready, 1);
    acc_mag = sav;
    read_frame("ovr");
    check("ovr_sticky", overrun, 1);
    set_random_bins();
    start_frame("ovr_next", 1'b1);
    read_frame("ovr_next");

    // out_req held high across the whole frame and into IDLE.
    set_random_bins();
    start_frame("hold", 1'b0);
    out_req = 1'b1;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (out_valid === 1'b1) begin
        if (n < 4) check("hold_byte", out_byte, acc_mag[n]);
        n++;
      end
    end
    out_req = 1'b0;
    check("hold_count", n, 4);
    check("hold_idle", busy, 0);

    // Reset after two bytes (state READY, overrun set).
    set_random_bins();
    start_frame("rmid", 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rmid_ovr", overrun, 1);
    read_byte("rmid", 0);
    read_byte("rmid", 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("rmid_rst");
    check("rmid_peak", peak_idx, 0);
    check("rmid_ovr_clr", overrun, 0);
    set_random_bins();
    start_frame("rnew", 1'b0);
    read_frame("rnew");

    // Reset during COMPUTE: nothing comes out afterwards.
    set_random_bins();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check_idle_outputs("rcomp");
      step();
    end

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      set_random_bins();
      start_frame("rnd", f[0]);
      read_frame("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
